// File: rtl/td4_pkg.sv
// td4_pkg: shared widths, memory reset word and loader state encoding for the TD4 tile
package td4_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int ROM_DEPTH = 1 << ADDR_W;
  localparam logic [7:0] ROM_RESET_WORD = 8'h00;
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, LOAD_ACK, RUN} ld_state_e;
endpackage

// File: rtl/td4_sync.sv
// td4_sync: multi-flop synchronizer for an asynchronous pin, resets to 0
module td4_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= '0;
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/td4_prog_loader.sv
// td4_prog_loader: loads TD4 program memory over a 4-phase strobe/ack handshake
// and serves CPU fetches from it, holding the CPU in reset while loading
import td4_pkg::*;
module td4_prog_loader #(
  parameter int ADDR_W      = td4_pkg::ADDR_W,
  parameter int DATA_W      = td4_pkg::DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              host_mode_i,
  input  logic              host_strobe_i,
  input  logic [DATA_W-1:0] host_data_i,
  output logic              host_ack_o,
  output logic [DATA_W-1:0] host_rdbk_o,
  output logic [ADDR_W:0]   load_cnt_o,
  output logic              cpu_rst_n_o,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic [DATA_W-1:0] cpu_instr_o
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);
  ld_state_e state, state_n;
  logic mode_s, strb_s, strb_d, rise, fall, we, ack_n, crst_n;
  logic [ADDR_W-1:0] wr_ptr, ptr_n;
  logic [ADDR_W:0] cnt_n;
  logic [DATA_W-1:0] mem [DEPTH];
  td4_sync #(.STAGES(SYNC_STAGES)) u_mode_sync (.clk(clk), .rst_n(rst_n), .d(host_mode_i), .q(mode_s));
  td4_sync #(.STAGES(SYNC_STAGES)) u_strb_sync (.clk(clk), .rst_n(rst_n), .d(host_strobe_i), .q(strb_s));
  // Edge history keeps sampling under ena=0 so a rise seen while frozen is consumed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) strb_d <= 1'b0;
    else strb_d <= strb_s;
  assign rise = strb_s & ~strb_d;
  assign fall = ~strb_s & strb_d;
  always_comb begin
    state_n = state;
    ptr_n = wr_ptr;
    cnt_n = load_cnt_o;
    ack_n = host_ack_o;
    crst_n = cpu_rst_n_o;
    we = 1'b0;
    case (state)
      IDLE: begin
        state_n = mode_s ? LOAD_WAIT : RUN;
        ptr_n = mode_s ? '0 : wr_ptr;
        cnt_n = mode_s ? '0 : load_cnt_o;
      end
      LOAD_WAIT: begin
        if (rise) begin
          we = 1'b1;
          ack_n = 1'b1;
          cnt_n = (load_cnt_o == CNT_MAX) ? load_cnt_o : load_cnt_o + 1'b1;
          state_n = LOAD_ACK;
        end else if (!mode_s) state_n = RUN;
      end
      LOAD_ACK: begin
        if (fall) begin
          ack_n = 1'b0;
          ptr_n = wr_ptr + 1'b1;
          state_n = LOAD_WAIT;
        end
      end
      RUN: begin
        crst_n = ~mode_s;
        state_n = mode_s ? LOAD_WAIT : RUN;
        ptr_n = mode_s ? '0 : wr_ptr;
        cnt_n = mode_s ? '0 : load_cnt_o;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      wr_ptr <= '0;
      load_cnt_o <= '0;
      host_ack_o <= 1'b0;
      cpu_rst_n_o <= 1'b0;
    end else if (ena) begin
      state <= state_n;
      wr_ptr <= ptr_n;
      load_cnt_o <= cnt_n;
      host_ack_o <= ack_n;
      cpu_rst_n_o <= crst_n;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(ROM_RESET_WORD);
    else if (ena && we) mem[wr_ptr] <= host_data_i;
  assign host_rdbk_o = (state == LOAD_WAIT || state == LOAD_ACK) ? mem[wr_ptr] : '0;
  assign cpu_instr_o = mem[cpu_addr_i];
endmodule

// File: tb/tb_td4_prog_loader.sv
// tb_td4_prog_loader: vector table, directed corner sequences and random loads checked
// against an array model of the program memory and handshake timing
module tb_td4_prog_loader;
  localparam int SYNC = 2;
  logic clk = 0, rst_n = 1, ena = 1, host_mode_i = 0, host_strobe_i = 0;
  logic [7:0] host_data_i = 0;
  logic host_ack_o, cpu_rst_n_o;
  logic [7:0] host_rdbk_o, cpu_instr_o;
  logic [4:0] load_cnt_o;
  logic [3:0] cpu_addr_i = 0;
  int checks = 0, errors = 0;
  logic [7:0] mem_m [16];
  int ptr_m = 0, cnt_m = 0;
  typedef struct {logic [7:0] din; logic [3:0] ra; logic [7:0] exp;} vec_t;
  vec_t tbl [16];

  td4_prog_loader #(.ADDR_W(4), .DATA_W(8), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .host_mode_i(host_mode_i),
    .host_strobe_i(host_strobe_i), .host_data_i(host_data_i), .host_ack_o(host_ack_o),
    .host_rdbk_o(host_rdbk_o), .load_cnt_o(load_cnt_o), .cpu_rst_n_o(cpu_rst_n_o),
    .cpu_addr_i(cpu_addr_i), .cpu_instr_o(cpu_instr_o));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_load();
    host_mode_i = 1;
    repeat (6) step();
    ptr_m = 0;
    cnt_m = 0;
  endtask

  task automatic enter_run();
    host_mode_i = 0;
    repeat (6) step();
  endtask

  task automatic wait_ack(input logic lvl, input string nm);
    int n = 0;
    do begin step(); n++; end while (host_ack_o !== lvl && n < 20);
    chk(nm, n, SYNC + 1);
  endtask

  task automatic write_byte(input logic [7:0] d);
    host_data_i = d;
    host_strobe_i = 1;
    wait_ack(1'b1, "ack_rise_lat");
    host_strobe_i = 0;
    wait_ack(1'b0, "ack_fall_lat");
    mem_m[ptr_m] = d;
    ptr_m = (ptr_m + 1) % 16;
    if (cnt_m < 16) cnt_m++;
  endtask

  task automatic check_mem(input string nm);
    for (int a = 0; a < 16; a++) begin
      cpu_addr_i = 4'(a);
      #1;
      chk(nm, cpu_instr_o, mem_m[a]);
    end
  endtask

  initial begin
    int n;
    for (int k = 0; k < 16; k++) begin
      mem_m[k] = 8'h00;
      tbl[k].din = 8'hB0 + 8'(k);
      tbl[k].ra = 4'(15 - k);
      tbl[k].exp = 8'hB0 + 8'(15 - k);
    end
    #1 rst_n = 0;
    #2;
    chk("rst_ack", host_ack_o, 0);
    chk("rst_cpu_rst_n", cpu_rst_n_o, 0);
    chk("rst_cnt", load_cnt_o, 0);
    chk("rst_rdbk", host_rdbk_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    step();
    n = 1;
    while (cpu_rst_n_o !== 1'b1 && n < 10) begin step(); n++; end
    chk("run_release_in_4", n <= 4, 1);
    check_mem("reset_mem");

    enter_load();
    chk("load_cpu_rst_n", cpu_rst_n_o, 0);
    chk("load_cnt0", load_cnt_o, 0);
    foreach (tbl[k]) write_byte(tbl[k].din);
    chk("cnt_16", load_cnt_o, 16);
    chk("load_cpu_rst_n_after", cpu_rst_n_o, 0);
    chk("rdbk_wrap", host_rdbk_o, 8'hB0);
    enter_run();
    chk("run_cpu_rst_n", cpu_rst_n_o, 1);
    chk("run_rdbk", host_rdbk_o, 0);
    foreach (tbl[k]) begin
      cpu_addr_i = tbl[k].ra;
      #1;
      chk("table_read", cpu_instr_o, tbl[k].exp);
    end

    enter_load();
    foreach (tbl[k]) write_byte(tbl[k].din);
    write_byte(8'h5A);
    chk("cnt_sat", load_cnt_o, 16);
    chk("rdbk_addr1", host_rdbk_o, 8'hB1);
    cpu_addr_i = 0;
    #1 chk("overwrite_addr0", cpu_instr_o, 8'h5A);
    cpu_addr_i = 1;
    #1 chk("keep_addr1", cpu_instr_o, 8'hB1);

    host_data_i = 8'h77;
    host_strobe_i = 1;
    wait_ack(1'b1, "mode_drop_ack_rise");
    host_mode_i = 0;
    repeat (6) step();
    chk("mode_drop_ack_held", host_ack_o, 1);
    chk("mode_drop_cpu_held", cpu_rst_n_o, 0);
    host_strobe_i = 0;
    wait_ack(1'b0, "mode_drop_ack_fall");
    mem_m[ptr_m] = 8'h77;
    repeat (6) step();
    chk("mode_drop_run", cpu_rst_n_o, 1);
    check_mem("mode_drop_mem");

    enter_load();
    ena = 0;
    host_data_i = 8'h3C;
    host_strobe_i = 1;
    repeat (6) step();
    chk("ena0_no_ack", host_ack_o, 0);
    host_strobe_i = 0;
    repeat (6) step();
    host_strobe_i = 1;
    repeat (6) step();
    chk("ena0_no_ack2", host_ack_o, 0);
    ena = 1;
    repeat (6) step();
    chk("ena1_consumed_ack", host_ack_o, 0);
    chk("ena1_consumed_cnt", load_cnt_o, 0);
    check_mem("ena_mem");
    host_strobe_i = 0;
    repeat (6) step();

    for (int r = 0; r < 4; r++) begin
      enter_load();
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        write_byte(8'($urandom));
        repeat ($urandom_range(0, 3)) step();
      end
      chk("rand_cnt", load_cnt_o, cnt_m);
      chk("rand_rdbk", host_rdbk_o, mem_m[ptr_m]);
      chk("rand_cpu_low", cpu_rst_n_o, 0);
      enter_run();
      chk("rand_cpu_high", cpu_rst_n_o, 1);
      check_mem("rand_mem");
    end

    enter_load();
    host_data_i = 8'hAA;
    host_strobe_i = 1;
    wait_ack(1'b1, "pre_reset_ack");
    #2 rst_n = 0;
    #1;
    chk("mid_rst_ack", host_ack_o, 0);
    chk("mid_rst_cpu", cpu_rst_n_o, 0);
    chk("mid_rst_cnt", load_cnt_o, 0);
    for (int k = 0; k < 16; k++) mem_m[k] = 8'h00;
    check_mem("mid_rst_mem");
    host_strobe_i = 0;
    host_mode_i = 0;
    @(negedge clk) rst_n = 1;
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
